ctrl_mac: RTL and testbench
===========================

Name: ctrl_mac

Overview:
- Control stage directly upstream of the bias-control stage in the gobou fully-connected pipeline.
- Takes the core's start/valid/stop stream and counts valid beats per output neuron.
- Generates accumulator-clear and accumulator-output-enable strobes for the MAC datapath.
- Emits a delayed ctrl_bus with one valid per completed dot product; that bus feeds the bias stage.

Parameters:
- D_MAC, 3: MAC datapath depth in cycles (multiply register + accumulate register + output); legal range 2..8.
- LEN_W, 16: width of the per-neuron input-length counter.

Ports:
- clk  in  1  clock.
- xrst  in  1  synchronous reset, active-low.
- in_ctrl  ctrl_bus.in  3  start/valid/stop from the core controller.
- in_len  in  LEN_W  products per neuron (N_IN); sampled on in_ctrl.start.
- out_ctrl  ctrl_bus.out  3  start/valid/stop to the bias stage.
- mac_first  out  1  clear accumulator; aligned with the first product of a neuron.
- mac_oe  out  1  accumulator holds final sum on the next edge.
- busy  out  1  layer in progress or pipeline draining.
- err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset: when xrst is low at a clk edge, all outputs, pipeline registers, counters, len_q and state clear to 0/IDLE. Reset mid-layer discards all in-flight beats, with no out_ctrl pulses afterwards.
- States:
  - IDLE -> ACC on in_ctrl.start.
  - ACC -> DRAIN on in_ctrl.stop.
  - DRAIN -> IDLE once the delayed stop has left the pipeline (D_MAC cycles after the stop input).
  - start seen in DRAIN -> ACC; the draining pulses still complete.
  - busy = (state != IDLE), registered.
- Start handling: len_q <= (in_len == 0 ? 1 : in_len); beat counter cnt <= 0. A start in ACC aborts any partial neuron: cnt <= 0 and no valid is emitted for the partial neuron.
- Beat handling (ACC only):
  - Beat = in_ctrl.valid && !in_ctrl.start.
  - first = (cnt == 0); last = (cnt == len_q-1).
  - On a beat: cnt <= last ? 0 : cnt+1.
  - valid low is a stall: cnt holds.
  - len_q == 1: first and last on every beat.
- Ignored inputs: valid in IDLE/DRAIN is ignored (no count, no outputs). Start has priority over a coincident valid. Stop with a coincident valid counts that beat first, then the layer ends.
- Latency, input at edge t:
  - out_ctrl.start at t+D_MAC.
  - out_ctrl.stop at t+D_MAC.
  - mac_first = first beat at t+D_MAC-1.
  - mac_oe = last beat at t+D_MAC-1.
  - out_ctrl.valid = last beat at t+D_MAC.
  - Implemented as a shift register of {start, first, last, stop} of depth D_MAC.
- Pulse widths: all output strobes are single-cycle per event. Back-to-back last beats give back-to-back valids.
- Stop with cnt != 0: the partial neuron is discarded (no mac_oe, no valid), and err is set when the feature is enabled.

Optional Feature:
- CTRL_MAC_CHECK_EN defined: err is set sticky (cleared only by reset) on any of:
  - valid in IDLE;
  - stop with cnt != 0;
  - start in ACC with cnt != 0;
  - start in_len == 0.
- Not defined: err is tied to 0 and the checking logic is absent. Functional behaviour of all other outputs is identical.

Test Plan:
- D_MAC=3, in_len=4: start@0, valid@1..8, stop@9 -> out start@3; mac_first@3,7; mac_oe@6,10; out valid@7,11; out stop@12; busy 1 from cycle 1 to 12, 0 at 13.
- in_len=3, valid@1,2,(gap 3),4,5,6,7 with stall at 3 -> last beats @4,7; out valid@7,10; cnt holds through the stall.
- in_len=1: valid@1..3 -> mac_first and mac_oe both @3,4,5; out valid@4,5,6.
- Stop after 2 of 4 beats -> no mac_oe/valid for the partial neuron; out stop@stop+3; err=1 with CHECK_EN, 0 without.
- xrst low at cycle 5 of the first scenario -> all outputs 0 from cycle 6; no later valid; busy 0; a fresh start then behaves as in scenario 1.
- in_len=0 at start -> treated as 1 (out valid per beat); err=1 with CHECK_EN.

Source files
------------

// File: rtl/ctrl_mac_if.sv
// ctrl_bus: start/valid/stop control stream between pipeline stages.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport in (input start, valid, stop);
  modport out (output start, valid, stop);
endinterface

// File: rtl/ctrl_mac.sv
// ctrl_mac: beat counter and strobe pipeline in front of the bias stage.
// Protocol checks on err are built only with `define CTRL_MAC_CHECK_EN.
module ctrl_mac #(
  parameter int D_MAC = 3,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             xrst,
  ctrl_bus.in              in_ctrl,
  input  logic [LEN_W-1:0] in_len,
  ctrl_bus.out             out_ctrl,
  output logic             mac_first,
  output logic             mac_oe,
  output logic             busy,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  typedef struct packed {
    logic start;
    logic first;
    logic last;
    logic stop;
  } tag_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [3:0]       dcnt;
  tag_t             sr [D_MAC];
  tag_t             tag;
  logic             acc;
  logic             beat;
  logic             is_first;
  logic             is_last;
  logic             stop_acc;
  logic             q_start;
  logic             q_valid;
  logic             q_stop;

  // dcnt times the drain so DRAIN ends as the stop leaves the pipe
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (stop_acc)
        dcnt <= 4'(D_MAC - 1);
      else if (dcnt != '0)
        dcnt <= dcnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_ctrl.start) state_nxt = ACC;
      ACC: if (stop_acc) state_nxt = DRAIN;
      DRAIN: begin
        if (in_ctrl.start)
          state_nxt = ACC;
        else if (dcnt == '0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc      = (state == ACC);
    beat     = acc && in_ctrl.valid && !in_ctrl.start;
    is_first = beat && (cnt == '0);
    is_last  = beat && (cnt == len_q - LEN_W'(1));
    stop_acc = acc && in_ctrl.stop && !in_ctrl.start;
    tag      = '{start: in_ctrl.start, first: is_first,
                 last: is_last, stop: stop_acc};
  end

  always_comb begin
    cnt_nxt = cnt;
    if (in_ctrl.start)
      cnt_nxt = '0;
    else if (beat)
      cnt_nxt = is_last ? '0 : cnt + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      len_q   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      q_start <= 1'b0;
      q_valid <= 1'b0;
      q_stop  <= 1'b0;
      for (int i = 0; i < D_MAC; i++)
        sr[i] <= '0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (state != IDLE);
      if (in_ctrl.start)
        len_q <= (in_len == '0) ? LEN_W'(1) : in_len;
      sr[0] <= tag;
      for (int i = 1; i < D_MAC; i++)
        sr[i] <= sr[i-1];
      q_start <= sr[D_MAC-1].start;
      q_valid <= sr[D_MAC-1].last;
      q_stop  <= sr[D_MAC-1].stop;
    end
  end

  assign mac_first      = sr[D_MAC-1].first;
  assign mac_oe         = sr[D_MAC-1].last;
  assign out_ctrl.start = q_start;
  assign out_ctrl.valid = q_valid;
  assign out_ctrl.stop  = q_stop;

`ifdef CTRL_MAC_CHECK_EN
  logic viol;

  always_comb begin
    viol = (state == IDLE && in_ctrl.valid && !in_ctrl.start)
        || (stop_acc && cnt_nxt != '0)
        || (acc && in_ctrl.start && cnt != '0)
        || (in_ctrl.start && in_len == '0);
  end

  always_ff @(posedge clk) begin
    if (!xrst)
      err <= 1'b0;
    else if (viol)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_mac.sv
// tb_ctrl_mac: directed and random streams against an event-time model.
module tb_ctrl_mac;
  localparam int D    = 3;
  localparam int LW   = 16;
  localparam int NMAX = 128;
`ifdef CTRL_MAC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          xrst;
  logic [LW-1:0] in_len;
  logic          mac_first;
  logic          mac_oe;
  logic          busy;
  logic          err;

  ctrl_bus in_ctrl();
  ctrl_bus out_ctrl();

  ctrl_mac #(.D_MAC(D), .LEN_W(LW)) dut (
    .clk(clk),
    .xrst(xrst),
    .in_ctrl(in_ctrl),
    .in_len(in_len),
    .out_ctrl(out_ctrl),
    .mac_first(mac_first),
    .mac_oe(mac_oe),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // bits: 6 start, 5 valid, 4 stop, 3 first, 2 oe, 1 busy, 0 err
  bit            st [NMAX];
  bit            vl [NMAX];
  bit            sp [NMAX];
  bit            rs [NMAX];
  logic [LW-1:0] ln [NMAX];
  logic [6:0]    obs [NMAX];
  logic [6:0]    expv [NMAX];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      st[i] = 0; vl[i] = 0; sp[i] = 0; rs[i] = 0; ln[i] = '0;
    end
  endtask

  task automatic idle_inputs();
    in_ctrl.start = 0;
    in_ctrl.valid = 0;
    in_ctrl.stop  = 0;
    in_len = '0;
  endtask

  task automatic run(input int n);
    xrst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      xrst = ~rs[t];
      in_ctrl.start = st[t];
      in_ctrl.valid = vl[t];
      in_ctrl.stop  = sp[t];
      in_len = ln[t];
      @(posedge clk);
      #1;
      obs[t] = {out_ctrl.start, out_ctrl.valid, out_ctrl.stop,
                mac_first, mac_oe, busy, err};
      @(negedge clk);
    end
    xrst = 1;
    idle_inputs();
  endtask

  // Events at input edge t land at t+D (bus) or t+D-1 (mac strobes)
  task automatic model(input int n);
    bit act = 0;
    int dend = -1;
    int cnt = 0;
    int len = 0;
    bit ef = 0;
    bit nonidle;
    for (int j = 0; j < NMAX; j++) expv[j] = '0;
    for (int t = 0; t < n; t++) begin
      if (rs[t]) begin
        for (int j = t; j < NMAX; j++) expv[j] = '0;
        act = 0; dend = -1; cnt = 0; len = 0; ef = 0;
        continue;
      end
      if (st[t]) begin
        if (act && cnt != 0) ef = 1;
        if (ln[t] == '0) ef = 1;
        len = (ln[t] == '0) ? 1 : int'(ln[t]);
        cnt = 0;
        act = 1;
        expv[t+D][6] = 1'b1;
      end else if (act) begin
        if (vl[t]) begin
          if (cnt == 0) expv[t+D-1][3] = 1'b1;
          if (cnt == len - 1) begin
            expv[t+D-1][2] = 1'b1;
            expv[t+D][5] = 1'b1;
            cnt = 0;
          end else begin
            cnt++;
          end
        end
        if (sp[t]) begin
          if (cnt != 0) ef = 1;
          expv[t+D][4] = 1'b1;
          act = 0;
          dend = t + D;
        end
      end else if (vl[t] && t > dend) begin
        ef = 1;
      end
      nonidle = act || (t < dend);
      expv[t][0] = CHK & ef;
      expv[t+1][1] = nonidle;
    end
  endtask

  task automatic test_reset();
    xrst = 0;
    for (int i = 0; i < 4; i++) begin
      in_ctrl.start = 1'($urandom);
      in_ctrl.valid = 1'($urandom);
      in_ctrl.stop  = 1'($urandom);
      in_len = LW'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_ctrl.start, out_ctrl.valid, out_ctrl.stop,
           mac_first, mac_oe, busy, err} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b want 0000000", i,
                 {out_ctrl.start, out_ctrl.valid, out_ctrl.stop,
                  mac_first, mac_oe, busy, err});
      end
      @(negedge clk);
    end
    xrst = 1;
    idle_inputs();
  endtask

  task automatic test_basic();
    logic want;
    clear_stim();
    st[0] = 1; ln[0] = 16'd4;
    for (int t = 1; t <= 8; t++) vl[t] = 1;
    sp[9] = 1;
    run(20);
    model(20);
    for (int t = 0; t < 20; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
      want = (t == 7 || t == 11);
      n_checks++;
      if (obs[t][5] !== want) begin
        n_fail++;
        $display("FAIL basic_valid cyc %0d: got %b want %b", t, obs[t][5], want);
      end
      want = (t >= 1 && t <= 12);
      n_checks++;
      if (obs[t][1] !== want) begin
        n_fail++;
        $display("FAIL basic_busy cyc %0d: got %b want %b", t, obs[t][1], want);
      end
    end
  endtask

  task automatic test_stall();
    logic want;
    clear_stim();
    st[0] = 1; ln[0] = 16'd3;
    vl[1] = 1; vl[2] = 1; vl[4] = 1; vl[5] = 1; vl[6] = 1; vl[7] = 1;
    sp[8] = 1;
    run(20);
    model(20);
    for (int t = 0; t < 20; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
      want = (t == 7 || t == 10);
      n_checks++;
      if (obs[t][5] !== want) begin
        n_fail++;
        $display("FAIL stall_valid cyc %0d: got %b want %b", t, obs[t][5], want);
      end
    end
  endtask

  task automatic test_len_one();
    logic [1:0] want;
    clear_stim();
    st[0] = 1; ln[0] = 16'd1;
    vl[1] = 1; vl[2] = 1; vl[3] = 1;
    sp[4] = 1;
    run(16);
    model(16);
    for (int t = 0; t < 16; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL len1 cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
      want = (t >= 3 && t <= 5) ? 2'b11 : 2'b00;
      n_checks++;
      if (obs[t][3:2] !== want) begin
        n_fail++;
        $display("FAIL len1_strobes cyc %0d: got %b want %b", t, obs[t][3:2], want);
      end
    end
  endtask

  task automatic test_partial_stop();
    clear_stim();
    st[0] = 1; ln[0] = 16'd4;
    vl[1] = 1; vl[2] = 1;
    sp[3] = 1;
    run(14);
    model(14);
    for (int t = 0; t < 14; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL partial cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
      n_checks++;
      if (obs[t][4] !== (t == 6) || obs[t][5] !== 1'b0 || obs[t][2] !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_strobes cyc %0d: got %b", t, obs[t]);
      end
    end
    n_checks++;
    if (obs[13][0] !== CHK) begin
      n_fail++;
      $display("FAIL partial_err: got %b want %b", obs[13][0], CHK);
    end
  endtask

  task automatic test_reset_mid();
    clear_stim();
    st[0] = 1; ln[0] = 16'd4;
    for (int t = 1; t <= 8; t++) vl[t] = 1;
    sp[9] = 1;
    rs[5] = 1;
    st[20] = 1; ln[20] = 16'd4;
    for (int t = 21; t <= 28; t++) vl[t] = 1;
    sp[29] = 1;
    run(45);
    model(45);
    for (int t = 0; t < 45; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL rstmid cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
      if (t >= 5 && t < 20) begin
        n_checks++;
        if (obs[t] !== 7'b0) begin
          n_fail++;
          $display("FAIL rstmid_quiet cyc %0d: got %b want 0000000", t, obs[t]);
        end
      end
    end
    n_checks++;
    if (obs[27][5] !== 1'b1 || obs[31][5] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_restart: got %b,%b want 1,1", obs[27][5], obs[31][5]);
    end
  endtask

  task automatic test_len_zero();
    clear_stim();
    st[0] = 1; ln[0] = 16'd0;
    vl[1] = 1; vl[2] = 1; vl[3] = 1;
    sp[4] = 1;
    run(14);
    model(14);
    for (int t = 0; t < 14; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL len0 cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
      n_checks++;
      if (obs[t][5] !== (t >= 4 && t <= 6)) begin
        n_fail++;
        $display("FAIL len0_valid cyc %0d: got %b", t, obs[t][5]);
      end
    end
    n_checks++;
    if (obs[13][0] !== CHK) begin
      n_fail++;
      $display("FAIL len0_err: got %b want %b", obs[13][0], CHK);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    st[0] = 1; ln[0] = 16'd3;
    vl[1] = 1; vl[2] = 1;
    st[3] = 1; ln[3] = 16'd2;
    vl[4] = 1; vl[5] = 1; vl[6] = 1; vl[7] = 1;
    sp[8] = 1;
    st[9] = 1; ln[9] = 16'd1;
    vl[10] = 1; vl[11] = 1;
    sp[12] = 1;
    vl[13] = 1; vl[20] = 1;
    run(28);
    model(28);
    for (int t = 0; t < 28; t++) begin
      n_checks++;
      if (obs[t] !== expv[t]) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %b want %b", t, obs[t], expv[t]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      clear_stim();
      for (int t = 0; t < 80; t++) begin
        st[t] = ($urandom_range(99) < 6);
        vl[t] = ($urandom_range(99) < 60);
        sp[t] = ($urandom_range(99) < 5);
        rs[t] = ($urandom_range(99) < 2);
        ln[t] = LW'($urandom_range(4));
      end
      run(90);
      model(90);
      for (int t = 0; t < 90; t++) begin
        n_checks++;
        if (obs[t] !== expv[t]) begin
          n_fail++;
          $display("FAIL random it %0d cyc %0d: got %b want %b",
                   it, t, obs[t], expv[t]);
        end
      end
    end
  endtask

  initial begin
    xrst = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_len_one();
    test_partial_stop();
    test_reset_mid();
    test_len_zero();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
